// File: rtl/grid_ram_arbiter.sv
// grid_ram_arbiter: H/S arbiter for a 2500-word grid RAM with lock and range check; ARB_ROUND_ROBIN_EN selects round-robin over fixed S priority
module grid_ram_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 2500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     h_req,
    input  logic                     s_req,
    input  logic                     h_we,
    input  logic                     s_we,
    input  logic                     h_lock,
    input  logic                     s_lock,
    input  logic [ADDRESS_WIDTH-1:0] h_addr,
    input  logic [ADDRESS_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0]    h_wdata,
    input  logic [DATA_WIDTH-1:0]    s_wdata,
    output logic                     h_gnt,
    output logic                     s_gnt,
    output logic                     h_rvalid,
    output logic                     s_rvalid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);
    typedef enum logic [1:0] {IDLE, LOCK_H, LOCK_S} state_t;
    localparam logic [ADDRESS_WIDTH-1:0] LIMIT = ADDRESS_WIDTH'(DEPTH);
    state_t state, state_next;
    logic s_wins, oor, tag_oor;
`ifdef ARB_ROUND_ROBIN_EN
    logic ptr;
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (h_gnt || s_gnt) ptr <= s_gnt;
    assign s_wins = ~ptr;
`else
    assign s_wins = 1'b1;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;
    // A lock owner that stops requesting forfeits the lock in the same cycle
    always_comb begin
        h_gnt = 1'b0;
        s_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCK_H && h_req) h_gnt = 1'b1;
            else if (state == LOCK_S && s_req) s_gnt = 1'b1;
            else if (h_req && s_req) begin
                s_gnt = s_wins;
                h_gnt = ~s_wins;
            end else begin
                h_gnt = h_req;
                s_gnt = s_req;
            end
        end
        state_next = h_gnt ? (h_lock ? LOCK_H : IDLE) : s_gnt ? (s_lock ? LOCK_S : IDLE) : IDLE;
    end
    always_comb begin
        ram_addr  = s_gnt ? s_addr : h_gnt ? h_addr : '0;
        ram_wdata = s_gnt ? s_wdata : h_gnt ? h_wdata : '0;
        oor       = (h_gnt || s_gnt) && ram_addr >= LIMIT;
        ram_we    = (s_gnt ? s_we : h_gnt && h_we) && !oor;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            h_rvalid <= 1'b0;
            s_rvalid <= 1'b0;
            tag_oor  <= 1'b0;
            err      <= 1'b0;
        end else begin
            h_rvalid <= h_gnt && !h_we;
            s_rvalid <= s_gnt && !s_we;
            tag_oor  <= oor;
            err      <= oor;
        end
    assign rdata = ((h_rvalid || s_rvalid) && !tag_oor) ? ram_rdata : '0;
endmodule
